// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the EX stage and the
// iterative RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start,
    output funct3,
    output op_a,
    output op_b,
    output flush,
    input  stall,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  funct3,
    input  op_a,
    input  op_b,
    input  flush,
    output stall,
    output done,
    output result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Radix-2 iterative RV32M multiply/divide unit with
// its pipeline stall/done sequencing controller.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ADJ,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       f3;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             neg;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic             is_div;
  logic             a_neg;
  logic             b_neg;
  logic             div0;
  logic             ovf;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] q_adj;
  logic [WIDTH-1:0] r_adj;
  logic [WIDTH-1:0] adj;
  logic [WIDTH-1:0] min_val;

  always_comb begin
    min_val = '0;
    min_val[WIDTH-1] = 1'b1;
    is_div = bus.funct3[2];
    if (is_div) begin
      a_neg = bus.op_a[WIDTH-1] & ~bus.funct3[0];
      b_neg = bus.op_b[WIDTH-1] & ~bus.funct3[0];
    end else begin
      a_neg = bus.op_a[WIDTH-1] &
              (bus.funct3[1] ^ bus.funct3[0]);
      b_neg = bus.op_b[WIDTH-1] &
              (bus.funct3[1:0] == 2'b01);
    end
    a_abs = a_neg ? -bus.op_a : bus.op_a;
    b_abs = b_neg ? -bus.op_b : bus.op_b;
    div0 = is_div & (bus.op_b == '0);
    ovf  = is_div & ~bus.funct3[0] &
           (bus.op_a == min_val) & (&bus.op_b);
    // multiply: add multiplicand when the low bit is set
    mul_sum = {1'b0, hi} +
              (lo[0] ? {1'b0, a_q} : '0);
    // divide: trial subtract of the shifted remainder
    shl  = {hi, lo[WIDTH-1]};
    diff = shl - {1'b0, b_q};
    prod  = neg ? -{hi, lo} : {hi, lo};
    q_adj = neg ? -lo : lo;
    r_adj = neg ? -hi : hi;
    if (f3[2]) begin
      adj = f3[1] ? r_adj : q_adj;
    end else if (f3[1:0] == 2'b00) begin
      adj = prod[WIDTH-1:0];
    end else begin
      adj = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      f3       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi       <= '0;
      lo       <= '0;
      neg      <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            f3 <= bus.funct3;
            unique case (1'b1)
              div0: begin
                result_q <= bus.funct3[1] ?
                            bus.op_a : '1;
                done_q   <= 1'b1;
                state    <= DONE;
              end
              ovf: begin
                result_q <= bus.funct3[1] ?
                            '0 : bus.op_a;
                done_q   <= 1'b1;
                state    <= DONE;
              end
              default: begin
                a_q   <= a_abs;
                b_q   <= b_abs;
                hi    <= '0;
                lo    <= is_div ? a_abs : b_abs;
                neg   <= (is_div && bus.funct3[1]) ?
                         a_neg : (a_neg ^ b_neg);
                cnt   <= CW'(WIDTH - 1);
                state <= CALC;
              end
            endcase
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            if (f3[2]) begin
              hi <= diff[WIDTH] ?
                    shl[WIDTH-1:0] : diff[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
              hi <= mul_sum[WIDTH:1];
              lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end
            if (cnt == '0) begin
              state <= ADJ;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        ADJ: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            result_q <= adj;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall = rst_n &
    (((state == IDLE) & bus.start & ~bus.flush) |
     (state == CALC) | (state == ADJ));
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector
// table, corner sequences and randomized model checks.
module tb_muldiv_sequencer;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [2:0] f3,
    input logic [31:0] a,
    input logic [31:0] b);
    logic [63:0] p;
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p  = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin
        p = sa * longint'(ub); return p[63:32];
      end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(
    input logic [2:0] f3,
    input logic [31:0] a,
    input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 &&
        b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic do_op(input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] exp,
                       input int lat,
                       input bit scramble,
                       input string nm);
    int n;
    bit seen;
    int serr;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.flush  = 1'b0;
    n = 0;
    seen = 1'b0;
    serr = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        if (bus.stall) serr++;
      end else begin
        if (!bus.stall) serr++;
        @(posedge clk); #1;
        n++;
        if (scramble && n >= 2) begin
          bus.funct3 = 3'($urandom);
          bus.op_a   = $urandom;
          bus.op_b   = $urandom;
        end
      end
    end
    chk({nm, " done"}, 32'(seen), 32'd1);
    chk({nm, " lat"}, n, lat);
    chk({nm, " res"}, bus.result, exp);
    chk({nm, " stall"}, serr, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;
    int          derr;
    total = 0;
    bad   = 0;

    vecs[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD,
                 32'hFFFF_FFEB, 34, "mul"};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000,
                 32'h4000_0000, 34, "mulh"};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFE, 34, "mulhu"};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF, 34, "mulhsu"};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,
                 32'hFFFF_FFFD, 34, "div"};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,
                 32'hFFFF_FFFF, 34, "rem"};
    vecs[6]  = '{3'd5, 32'd100, 32'd7,
                 32'd14, 34, "divu"};
    vecs[7]  = '{3'd7, 32'd100, 32'd7,
                 32'd2, 34, "remu"};
    vecs[8]  = '{3'd5, 32'h1234, 32'd0,
                 32'hFFFF_FFFF, 1, "divu0"};
    vecs[9]  = '{3'd6, 32'h1234, 32'd0,
                 32'h1234, 1, "rem0"};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'h8000_0000, 1, "divovf"};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'd0, 1, "removf"};
    vecs[12] = '{3'd4, 32'h8000_0000, 32'd1,
                 32'h8000_0000, 34, "divmin"};
    vecs[13] = '{3'd6, 32'd7, 32'hFFFF_FFFE,
                 32'd1, 34, "remneg"};

    // reset behaviour, with start held high
    rst_n      = 1'b0;
    bus.start  = 1'b1;
    bus.funct3 = 3'd0;
    bus.op_a   = 32'd1;
    bus.op_b   = 32'd1;
    bus.flush  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst stall", 32'(bus.stall), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst result", bus.result, 32'd0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle stall", 32'(bus.stall), 32'd0);

    foreach (vecs[i]) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b,
            vecs[i].exp, vecs[i].lat, 1'b0,
            vecs[i].nm);
    end

    do_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678,
          model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678),
          34, 1'b1, "scr mulhu");
    do_op(3'd4, 32'hF000_0001, 32'd13,
          model(3'd4, 32'hF000_0001, 32'd13),
          34, 1'b1, "scr div");

    // flush mid-divide, then a fresh multiply
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.funct3 = 3'd4;
    bus.op_a   = 32'd1000;
    bus.op_b   = 32'd3;
    derr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.done || !bus.stall) derr++;
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    if (bus.done || !bus.stall) derr++;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("flush stall11", 32'(bus.stall), 32'd0);
    chk("flush done11", 32'(bus.done), 32'd0);
    chk("flush pre", derr, 0);
    bus.start  = 1'b1;
    bus.funct3 = 3'd0;
    bus.op_a   = 32'd3;
    bus.op_b   = 32'd5;
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("flush mul lat", n, 34);
    chk("flush mul res", bus.result, 32'd15);
    @(posedge clk); #1;
    bus.start = 1'b0;

    // asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.funct3 = 3'd4;
    bus.op_a   = 32'd999;
    bus.op_b   = 32'd7;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst stall", 32'(bus.stall), 32'd0);
    chk("arst done", 32'(bus.done), 32'd0);
    chk("arst result", bus.result, 32'd0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(3'd7, 32'd1000, 32'd7, 32'd6, 34,
          1'b0, "post rst");

    for (int k = 0; k < 40; k++) begin
      rf3 = 3'($urandom);
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = $urandom_range(0, 50);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      do_op(rf3, ra, rb, model(rf3, ra, rb),
            lat_of(rf3, ra, rb), k[0], "rand");
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit and its sequencing controller for the RV32M extension. Sits beside the EX-stage ALU.
- Accepts one M-type instruction from the ID/EX register and stalls the pipeline while it iterates.
- Presents a one-cycle-valid result to the EX/MEM write path, then releases the stall.
- Handles divide-by-zero and signed overflow as single-cycle fast paths.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH; counter width is clog2(WIDTH).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  EX holds a valid M-extension instruction
funct3  in  3  RV32M operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  in  WIDTH  rs1 value (forwarded)
op_b  in  WIDTH  rs2 value (forwarded)
flush  in  1  kill the EX instruction (branch/jump taken)
stall  out  1  hold PC, IF/ID and ID/EX registers
done  out  1  result valid this cycle
result  out  WIDTH  operation result, registered

Behaviour:
- Reset: asynchronous on rst_n low, takes effect immediately. State=IDLE, counter=0, internal registers=0, done=0, result=0. stall=0 while in reset. Reset mid-operation abandons the operation silently.
- States: IDLE, CALC, ADJ, DONE.
- IDLE, start=1 and flush=0: latch funct3, op_a, op_b. Later changes on these inputs are ignored until the next IDLE.
  - Divide by zero (funct3[2]=1, op_b=0): go to DONE. Quotient = all ones; remainder = op_a.
  - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): go to DONE. DIV result = 0x80000000; REM result = 0.
  - Otherwise: go to CALC with counter=WIDTH-1. Store magnitudes of signed operands: MULH both operands, MULHSU op_a only, DIV/REM both operands. Record result sign.
- CALC: one radix-2 step per cycle; counter decrements, WIDTH cycles total; on counter=0 go to ADJ.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- ADJ: apply sign correction, then load result.
  - Multiply: negate the 2*WIDTH product if the sign is negative. MUL takes the low half; MULH/MULHSU/MULHU take the high half.
  - DIV: quotient sign = sign(a) XOR sign(b).
  - REM: remainder takes the sign of op_a.
  - Go to DONE.
- DONE: done=1, stall=0; pipeline advances this cycle and consumes result. Next state is IDLE. start seen in DONE is ignored (same instruction still present).
- stall = (IDLE & start & ~flush) | CALC | ADJ. stall=0 in DONE and in idle without start.
- Latency:
  - Normal op: start accepted in cycle 0; done=1 in cycle WIDTH+2 (cycle 34 for WIDTH=32). The pipeline is held for WIDTH+2 cycles.
  - Fast path: done in cycle 1.
- result holds its value after DONE until the next load. It is meaningful only while done=1.
- flush in CALC or ADJ: next state IDLE, done stays 0, result unchanged, stall=0 from the next cycle.
- flush in IDLE: start is not accepted.
- flush in DONE: DONE still exits to IDLE; done stays asserted for that cycle, and the pipeline discards it via its own flush.
- Counter never wraps; it is only loaded on entry to CALC.
- Non-M instructions never assert start; the block is inert for them.

Test Plan:
- MUL 7 x 0xFFFFFFFD: result 0xFFFFFFEB; done exactly in cycle 34; stall high cycles 0..33, low in cycle 34.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide/remainder:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Special cases complete with done in cycle 1:
  - DIVU 0x1234 / 0 -> 0xFFFFFFFF; REM 0x1234 / 0 -> 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Flush and operand stability:
  - Start DIV, assert flush in cycle 10: IDLE in cycle 11, stall=0, done never rises. A new MUL 3 x 5 accepted in cycle 11 -> 15 in cycle 45.
  - Changing op_a/op_b mid-CALC does not affect the result.
- Drop rst_n asynchronously in cycle 20 of a DIV: stall, done and result drop to 0 without a clock edge. After release, IDLE accepts a new start normally.
